// File: rtl/alsu_issue_seq.sv
// Issue sequencer in front of the ALSU: queues commands, drives the ALSU ports,
// tracks the fixed ALSU latency and buffers results under a credit limit.
module alsu_issue_seq #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int LAT       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic signed [2:0] in_A_i,
    input  logic signed [2:0] in_B_i,
    input  logic [2:0]        in_opcode_i,
    input  logic              in_cin_i,
    input  logic              in_serial_in_i,
    input  logic              in_direction_i,
    input  logic              in_red_op_A_i,
    input  logic              in_red_op_B_i,
    input  logic              in_bypass_A_i,
    input  logic              in_bypass_B_i,
    output logic signed [2:0] A_o,
    output logic signed [2:0] B_o,
    output logic [2:0]        opcode_o,
    output logic              cin_o,
    output logic              serial_in_o,
    output logic              direction_o,
    output logic              red_op_A_o,
    output logic              red_op_B_o,
    output logic              bypass_A_o,
    output logic              bypass_B_o,
    input  logic [5:0]        alsu_out_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [5:0]        res_out_o,
    output logic              res_invalid_o,
    output logic              busy_o
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(RES_DEPTH);
    localparam int RCW = RPW + 1;
    localparam int CRW = $clog2(RES_DEPTH + 1);

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serialIn;
        logic       direction;
        logic       redOpA;
        logic       redOpB;
        logic       bypassA;
        logic       bypassB;
    } cmd_t;

    cmd_t             cmdMem_q [CMD_DEPTH];
    logic [CPW-1:0]   cmdWr_q, cmdRd_q;
    logic [CCW-1:0]   cmdCnt_q, cmdCnt_d;
    logic             rdyEn_q;
    cmd_t             port_q;
    logic [1:0]       tag_q [LAT+1];
    logic [6:0]       resMem_q [RES_DEPTH];
    logic [RPW-1:0]   resWr_q, resRd_q;
    logic [RCW-1:0]   resCnt_q, resCnt_d;
    logic [CRW-1:0]   cred_q, cred_d;

    cmd_t inCmd, cmdHead;
    logic cmdEmpty, cmdFull, resEmpty;
    logic push, issue, resPop, capture, headInv;

    assign inCmd = '{a: in_A_i, b: in_B_i, opcode: in_opcode_i, cin: in_cin_i,
                     serialIn: in_serial_in_i, direction: in_direction_i,
                     redOpA: in_red_op_A_i, redOpB: in_red_op_B_i,
                     bypassA: in_bypass_A_i, bypassB: in_bypass_B_i};

    assign cmdHead  = cmdMem_q[cmdRd_q];
    assign cmdEmpty = (cmdCnt_q == '0);
    assign cmdFull  = (cmdCnt_q == CCW'(CMD_DEPTH));
    assign resEmpty = (resCnt_q == '0);
    assign resPop   = !resEmpty && res_ready_i;
    // A pop frees a credit on the same edge, so issue may proceed at the limit.
    assign issue    = !cmdEmpty && ((cred_q < CRW'(RES_DEPTH)) || resPop);
    assign in_ready_o = rdyEn_q && (!cmdFull || issue);
    assign push     = in_valid_i && in_ready_o;
    assign capture  = tag_q[LAT][1];
    assign headInv  = ((cmdHead.redOpA | cmdHead.redOpB) & (cmdHead.opcode[1] | cmdHead.opcode[2]))
                    | (cmdHead.opcode[1] & cmdHead.opcode[2]);

    always_comb begin
        cmdCnt_d = cmdCnt_q;
        resCnt_d = resCnt_q;
        cred_d   = cred_q;
        if (push && !issue)      cmdCnt_d = cmdCnt_q + CCW'(1);
        else if (!push && issue) cmdCnt_d = cmdCnt_q - CCW'(1);
        if (capture && !resPop)      resCnt_d = resCnt_q + RCW'(1);
        else if (!capture && resPop) resCnt_d = resCnt_q - RCW'(1);
        if (issue && !resPop)      cred_d = cred_q + CRW'(1);
        else if (!issue && resPop) cred_d = cred_q - CRW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) cmdMem_q[cmdWr_q] <= inCmd;
        if (capture) resMem_q[resWr_q] <= {tag_q[LAT][0], alsu_out_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdWr_q  <= '0;
            cmdRd_q  <= '0;
            cmdCnt_q <= '0;
            rdyEn_q  <= 1'b0;
            resWr_q  <= '0;
            resRd_q  <= '0;
            resCnt_q <= '0;
            cred_q   <= '0;
            port_q   <= '0;
        end else begin
            rdyEn_q  <= 1'b1;
            cmdCnt_q <= cmdCnt_d;
            resCnt_q <= resCnt_d;
            cred_q   <= cred_d;
            if (push)    cmdWr_q <= cmdWr_q + CPW'(1);
            if (issue)   cmdRd_q <= cmdRd_q + CPW'(1);
            if (capture) resWr_q <= resWr_q + RPW'(1);
            if (resPop)  resRd_q <= resRd_q + RPW'(1);
            // Idle edges drive all-zero ports so the ALSU output settles at 0.
            port_q <= issue ? cmdHead : '0;
        end
    end

    // Stage 0 lines up with the port registers; stage LAT with a valid alsu_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= LAT; i++) tag_q[i] <= 2'b00;
        end else begin
            tag_q[0] <= {issue, issue & headInv};
            for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign A_o         = port_q.a;
    assign B_o         = port_q.b;
    assign opcode_o    = port_q.opcode;
    assign cin_o       = port_q.cin;
    assign serial_in_o = port_q.serialIn;
    assign direction_o = port_q.direction;
    assign red_op_A_o  = port_q.redOpA;
    assign red_op_B_o  = port_q.redOpB;
    assign bypass_A_o  = port_q.bypassA;
    assign bypass_B_o  = port_q.bypassB;

    assign res_valid_o = !resEmpty;
    assign {res_invalid_o, res_out_o} = resEmpty ? 7'd0 : resMem_q[resRd_q];
    assign busy_o = !cmdEmpty || (cred_q != '0);

endmodule

// File: tb/tb_alsu_issue_seq.sv
// Directed bench for alsu_issue_seq with a behavioural two-stage ALSU model
// attached to its port registers.
module tb_alsu_issue_seq;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serialIn;
        logic       direction;
        logic       redOpA;
        logic       redOpB;
        logic       bypassA;
        logic       bypassB;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inValid = 1'b0;
    logic inReady;
    cmd_t inCmd = '0;
    logic signed [2:0] portA, portB;
    logic [2:0] portOp;
    logic portCin, portSerial, portDir, portRedA, portRedB, portBypA, portBypB;
    logic [5:0] alsuOut;
    logic resValid, resInvalid, busy;
    logic resReady = 1'b1;
    logic [5:0] resOut;

    int checkCount = 0;
    int passCount = 0;

    always #5 clk = ~clk;

    alsu_issue_seq #(.CMD_DEPTH(4), .RES_DEPTH(4), .LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .in_A_i(inCmd.a), .in_B_i(inCmd.b), .in_opcode_i(inCmd.opcode),
        .in_cin_i(inCmd.cin), .in_serial_in_i(inCmd.serialIn),
        .in_direction_i(inCmd.direction), .in_red_op_A_i(inCmd.redOpA),
        .in_red_op_B_i(inCmd.redOpB), .in_bypass_A_i(inCmd.bypassA),
        .in_bypass_B_i(inCmd.bypassB),
        .A_o(portA), .B_o(portB), .opcode_o(portOp), .cin_o(portCin),
        .serial_in_o(portSerial), .direction_o(portDir),
        .red_op_A_o(portRedA), .red_op_B_o(portRedB),
        .bypass_A_o(portBypA), .bypass_B_o(portBypB),
        .alsu_out_i(alsuOut),
        .res_valid_o(resValid), .res_ready_i(resReady),
        .res_out_o(resOut), .res_invalid_o(resInvalid), .busy_o(busy)
    );

    // ALSU model: input register stage, then registered output
    cmd_t aluIn;

    function automatic logic [5:0] alsuCompute(input cmd_t c, input logic [5:0] prev);
        logic signed [2:0] sa, sb;
        logic signed [5:0] r;
        logic inv;
        sa = c.a;
        sb = c.b;
        inv = ((c.redOpA | c.redOpB) & (c.opcode[1] | c.opcode[2])) | (c.opcode[1] & c.opcode[2]);
        r = '0;
        if (inv) r = '0;
        else if (c.bypassA) r = 6'(sa);
        else if (c.bypassB) r = 6'(sb);
        else begin
            case (c.opcode)
                3'd0: r = c.redOpA ? {5'd0, &c.a} : c.redOpB ? {5'd0, &c.b} : 6'(sa & sb);
                3'd1: r = c.redOpA ? {5'd0, ^c.a} : c.redOpB ? {5'd0, ^c.b} : 6'(sa ^ sb);
                3'd2: r = sa + sb + $signed({1'b0, c.cin});
                3'd3: r = sa * sb;
                3'd4: r = c.direction ? {prev[4:0], c.serialIn} : {c.serialIn, prev[5:1]};
                3'd5: r = c.direction ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluIn   <= '0;
            alsuOut <= '0;
        end else begin
            aluIn   <= '{a: portA, b: portB, opcode: portOp, cin: portCin, serialIn: portSerial,
                         direction: portDir, redOpA: portRedA, redOpB: portRedB,
                         bypassA: portBypA, bypassB: portBypB};
            alsuOut <= alsuCompute(aluIn, alsuOut);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Present one command and hold it until the sequencer accepts it
    task automatic applyStimulus(input cmd_t c);
        inCmd = c;
        inValid = 1'b1;
        for (int k = 0; k < 40 && !inReady; k++) step();
        checkOutput("inReadyForCmd", 32'(inReady), 1);
        step();
        inValid = 1'b0;
    endtask

    task automatic waitResult(input string tag, input logic [5:0] expOut, input logic expInv);
        for (int k = 0; k < 40 && !resValid; k++) step();
        checkOutput({tag, "Valid"}, 32'(resValid), 1);
        checkOutput(tag, 32'(resOut), 32'(expOut));
        checkOutput({tag, "Inv"}, 32'(resInvalid), 32'(expInv));
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmd_t c;
        cmd_t bpCmd [8];
        logic [5:0] bpExp [8];
        int accepted;
        logic seenValid;

        // Reset held with a pending command: nothing may be accepted
        inCmd = '{a: 3'd1, b: 3'd1, opcode: 3'd2, default: 1'b0};
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("inReadyInReset", 32'(inReady), 0);
        end
        inValid = 1'b0;
        rst_n = 1'b1;
        checkOutput("busyAfterReset", 32'(busy), 0);
        checkOutput("resValidAfterReset", 32'(resValid), 0);
        checkOutput("resOutAfterReset", 32'(resOut), 0);
        checkOutput("idlePorts", {16'd0, portA, portB, portOp, portCin, portSerial, portDir,
                                  portRedA, portRedB, portBypA, portBypB}, 0);
        step();
        checkOutput("inReadyAfterRelease", 32'(inReady), 1);

        // Add 3+2+1: accept edge E0, ports after E0+1, result after E0+4
        c = '0; c.a = 3'd3; c.b = 3'd2; c.cin = 1'b1; c.opcode = 3'd2;
        applyStimulus(c);
        step();
        checkOutput("addPortA", 32'(portA), 3);
        checkOutput("addPortOp", 32'(portOp), 2);
        step();
        checkOutput("addNotYet2", 32'(resValid), 0);
        step();
        checkOutput("addNotYet3", 32'(resValid), 0);
        step();
        checkOutput("addValid", 32'(resValid), 1);
        checkOutput("addOut", 32'(resOut), 6);
        checkOutput("addInv", 32'(resInvalid), 0);
        step();
        checkOutput("addPopped", 32'(resValid), 0);
        checkOutput("addIdleBusy", 32'(busy), 0);

        // Multiply -2*3, then invalid opcode 6, results in order
        c = '0; c.a = 3'b110; c.b = 3'd3; c.opcode = 3'd3;
        applyStimulus(c);
        c = '0; c.a = 3'd1; c.opcode = 3'd6;
        applyStimulus(c);
        waitResult("mul", 6'b111010, 1'b0);
        waitResult("op6", 6'b000000, 1'b1);

        // Back-pressure: 10 attempts with res_ready low
        for (int i = 0; i < 8; i++) begin
            bpCmd[i] = '0;
            bpCmd[i].a = 3'(i);
            bpCmd[i].b = 3'd1;
            bpCmd[i].opcode = 3'd2;
        end
        bpExp = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h3D, 6'h3E, 6'h3F, 6'h00};
        for (int i = 0; i < 4; i++) step();
        resReady = 1'b0;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            inCmd = bpCmd[accepted % 8];
            inValid = 1'b1;
            if (inReady) accepted++;
            step();
        end
        inValid = 1'b0;
        checkOutput("bpAccepted", 32'(accepted), 8);
        checkOutput("bpInReadyLow", 32'(inReady), 0);
        checkOutput("bpBusy", 32'(busy), 1);
        checkOutput("bpHeadValid", 32'(resValid), 1);
        checkOutput("bpHeadOut", 32'(resOut), 32'(bpExp[0]));
        step();
        step();
        checkOutput("bpHeadHold", 32'(resOut), 32'(bpExp[0]));
        resReady = 1'b1;
        for (int i = 0; i < 8; i++) waitResult($sformatf("bpRes%0d", i), bpExp[i], 1'b0);
        step();
        checkOutput("bpDrained", 32'(resValid), 0);
        checkOutput("bpBusyDone", 32'(busy), 0);

        // Shift left after idle, then the same command back-to-back
        for (int i = 0; i < 3; i++) step();
        c = '0; c.opcode = 3'd4; c.direction = 1'b1; c.serialIn = 1'b1;
        applyStimulus(c);
        applyStimulus(c);
        waitResult("shift1", 6'b000001, 1'b0);
        waitResult("shift2", 6'b000011, 1'b0);

        // Reset pulse with three commands in flight
        for (int i = 0; i < 3; i++) step();
        c = '0; c.a = 3'd1; c.b = 3'd1; c.opcode = 3'd2;
        applyStimulus(c);
        applyStimulus(c);
        applyStimulus(c);
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        seenValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resValid) seenValid = 1'b1;
        end
        checkOutput("noStaleResult", 32'(seenValid), 0);
        checkOutput("busyAfterPulse", 32'(busy), 0);
        checkOutput("credAfterPulse", 32'(dut.cred_q), 0);
        c = '0; c.a = 3'd3; c.b = 3'd2; c.cin = 1'b1; c.opcode = 3'd2;
        applyStimulus(c);
        waitResult("recover", 6'd6, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
